// File: rtl/endstop_pkg.sv
// Shared field widths and the event record carried from the endstop stage
// into the event log FIFO.
package endstop_pkg;

  localparam int POS_W = 64;
  localparam int CYC_W = 8;
  localparam int TS_W  = 32;
  localparam int OVF_W = 16;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic             level;
    logic [POS_W-1:0] pos;
    logic [CYC_W-1:0] cycles;
  } endstop_event_t;

  localparam int EVT_W = $bits(endstop_event_t);

endpackage

// File: rtl/endstop_event_log_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is always
// presented on rd_data. The occupancy count is the authoritative full/empty
// indicator, so the pointers need no extra wrap bit.
module event_fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy; clear wins.
  always_comb begin
    pop_ok   = pop && !empty && !clear;
    push_ok  = push && (!full || pop_ok) && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/endstop_event_log.sv
// Timestamps debounced endstop edges and buffers them for the host. Events
// arriving while the buffer is full are dropped and counted.
module endstop_event_log
  import endstop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             signal,
  input  logic             signal_changed,
  input  logic [63:0]      pos_in,
  input  logic [7:0]       cycles_in,
  input  logic             rd_pop,
  output logic             rd_valid,
  output logic             rd_level,
  output logic [63:0]      rd_pos,
  output logic [7:0]       rd_cycles,
  output logic [31:0]      rd_timestamp,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      overflow_count,
  output logic [31:0]      timestamp
);

  logic [TS_W-1:0]  timestamp_q, timestamp_d;
  logic [OVF_W-1:0] overflow_q, overflow_d;
  logic             push_req, pop_req, pop_eff, drop;
  logic             fifo_full, fifo_empty;
  endstop_event_t   wr_event, rd_event;

  assign push_req = enable && signal_changed && !clear;
  assign pop_req  = rd_pop && !clear;
  assign pop_eff  = pop_req && !fifo_empty;
  assign drop     = push_req && fifo_full && !pop_eff;

  assign wr_event = '{ts: timestamp_q, level: signal, pos: pos_in, cycles: cycles_in};

  event_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push_req),
    .pop     (pop_req),
    .wr_data (wr_event),
    .rd_data (rd_event),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Free-running timestamp and saturating drop counter next-state.
  always_comb begin
    timestamp_d = timestamp_q + TS_W'(1);
    overflow_d  = overflow_q;
    if (clear) begin
      overflow_d = '0;
    end else if (drop && (overflow_q != '1)) begin
      overflow_d = overflow_q + OVF_W'(1);
    end
  end

  // Timestamp and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      timestamp_q <= '0;
      overflow_q  <= '0;
    end else begin
      timestamp_q <= timestamp_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rd_valid       = !fifo_empty;
  assign rd_level       = rd_valid ? rd_event.level  : 1'b0;
  assign rd_pos         = rd_valid ? rd_event.pos    : '0;
  assign rd_cycles      = rd_valid ? rd_event.cycles : '0;
  assign rd_timestamp   = rd_valid ? rd_event.ts     : '0;
  assign overflow_count = overflow_q;
  assign timestamp      = timestamp_q;

endmodule
